// File: rtl/bot_evt_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bot_evt_pkg
// Purpose  : Shared definitions for the BOTSIM event queue: record field
//            layout, IRQ handshake state encoding, default queue depth and
//            the drop counter saturation value.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package bot_evt_pkg;

  // Queue depth default (records) and record width
  localparam int unsigned c_DEPTH_DEF = 8;
  localparam int unsigned c_REC_W     = 32;
  localparam int unsigned c_FIELD_W   = 8;

  // Bit offsets of each field inside a 32-bit event record
  localparam int unsigned c_LOCX_LSB  = 0;
  localparam int unsigned c_LOCY_LSB  = 8;
  localparam int unsigned c_SENS_LSB  = 16;
  localparam int unsigned c_INFO_LSB  = 24;

  // drop_cnt holds at this value once reached
  localparam logic [7:0]  c_DROP_SAT  = 8'd255;

  // Interrupt handshake states toward the Application CPU
  typedef enum logic [1:0] {
    IRQ_IDLE    = 2'd0,
    IRQ_REQ     = 2'd1,
    IRQ_SERVICE = 2'd2
  } irq_state_e;

  // Assemble one event record from the BOTSIM register fields
  function automatic logic [c_REC_W-1:0] pack_rec(
    input logic [c_FIELD_W-1:0] botinfo,
    input logic [c_FIELD_W-1:0] sensors,
    input logic [c_FIELD_W-1:0] locy,
    input logic [c_FIELD_W-1:0] locx
  );
    return {botinfo, sensors, locy, locx};
  endfunction

endpackage
`default_nettype wire

// File: rtl/bot_evt_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bot_evt_fifo
// Purpose  : Synchronous first-word-fall-through FIFO. The head word is
//            presented combinationally and forced to zero while empty.
//            A push into a full FIFO is accepted only when a pop retires the
//            head on the same edge; a pop on an empty FIFO is ignored.
// Ports    : clk, rst_n      - clock, asynchronous active-low reset
//            i_push, i_wdata - write request and data
//            i_pop           - discard head request
//            o_rdata         - head word (0 when empty)
//            o_count         - words held, 0..DEPTH
//            o_full/o_empty  - occupancy flags
//            o_push_ok       - push accepted this cycle
// Revision : 1.0 - initial release
// ============================================================================
module bot_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int W     = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_pop,
  output logic [W-1:0]  o_rdata,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty,
  output logic          o_push_ok
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_pop_ok  = i_pop & ~o_empty;
  // A full FIFO still takes a push when the head leaves on the same edge
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_push_ok = w_push_ok;

  // Storage is intentionally not reset
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally at AW bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_rdata = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule
`default_nettype wire

// File: rtl/bot_evt_queue.sv
`default_nettype none
// ============================================================================
// Module   : bot_evt_queue
// Purpose  : Captures a BOTSIM system-register snapshot on every rising edge
//            of upd_sysregs into an FWFT queue, counts records dropped while
//            full, and runs a request/acknowledge interrupt handshake toward
//            the Application CPU.
// Ports    : clk, reset             - clock, asynchronous active-low reset
//            upd_sysregs            - BOTSIM update level
//            LocX/LocY/Sensors/BotInfo_in - BOTSIM register values
//            pop                    - discard head record
//            irq_ack                - CPU acknowledge of irq_req
//            clr_ovf                - clear overflow and drop_cnt
//            evt_valid, evt_*       - head record (0 when empty)
//            count                  - records held
//            overflow, drop_cnt     - drop accounting
//            irq_req                - interrupt request
// Revision : 1.0 - initial release
// ============================================================================
module bot_evt_queue
  import bot_evt_pkg::*;
#(
  parameter int DEPTH = c_DEPTH_DEF,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          upd_sysregs,
  input  logic [7:0]    LocX_in,
  input  logic [7:0]    LocY_in,
  input  logic [7:0]    Sensors_in,
  input  logic [7:0]    BotInfo_in,
  input  logic          pop,
  input  logic          irq_ack,
  input  logic          clr_ovf,
  output logic          evt_valid,
  output logic [7:0]    evt_LocX,
  output logic [7:0]    evt_LocY,
  output logic [7:0]    evt_Sensors,
  output logic [7:0]    evt_BotInfo,
  output logic [AW:0]   count,
  output logic          overflow,
  output logic [7:0]    drop_cnt,
  output logic          irq_req
);

  logic               r_upd_q;
  logic               r_overflow;
  logic [7:0]         r_drop_cnt;
  logic               r_irq_req;
  irq_state_e         r_state;

  logic               w_push;
  logic               w_drop;
  logic               w_push_ok;
  logic               w_full;
  logic               w_empty;
  logic [c_REC_W-1:0] w_wdata;
  logic [c_REC_W-1:0] w_head;
  logic [AW:0]        w_count;

  // Rising-edge detect: a level held high yields a single push. upd_q resets
  // low so a level already high at reset release is captured once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_upd_q <= 1'b0;
    end else begin
      r_upd_q <= upd_sysregs;
    end
  end

  assign w_push  = upd_sysregs & ~r_upd_q;
  assign w_wdata = pack_rec(BotInfo_in, Sensors_in, LocY_in, LocX_in);

  bot_evt_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (c_REC_W)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .i_push    (w_push),
    .i_wdata   (w_wdata),
    .i_pop     (pop),
    .o_rdata   (w_head),
    .o_count   (w_count),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_push_ok (w_push_ok)
  );

  // Only a push refused by a full queue counts as a drop
  assign w_drop = w_push & w_full & ~w_push_ok;

  // A clear on the same edge as a drop is applied first, so the drop
  // restarts the count at 1 and leaves overflow set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (clr_ovf) begin
        r_drop_cnt <= 8'd1;
      end else if (r_drop_cnt != c_DROP_SAT) begin
        r_drop_cnt <= r_drop_cnt + 8'd1;
      end
    end else if (clr_ovf) begin
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  // IRQ handshake. After an acknowledge the request stays low until the
  // queue has drained once, so the CPU services a batch per interrupt.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IRQ_IDLE;
      r_irq_req <= 1'b0;
    end else begin
      case (r_state)
        IRQ_IDLE: begin
          if (w_count != '0) begin
            r_state   <= IRQ_REQ;
            r_irq_req <= 1'b1;
          end
        end
        IRQ_REQ: begin
          if (irq_ack) begin
            r_state   <= IRQ_SERVICE;
            r_irq_req <= 1'b0;
          end
        end
        IRQ_SERVICE: begin
          if (w_count == '0) begin
            r_state   <= IRQ_IDLE;
            r_irq_req <= 1'b0;
          end
        end
        default: begin
          r_state   <= IRQ_IDLE;
          r_irq_req <= 1'b0;
        end
      endcase
    end
  end

  assign evt_valid   = ~w_empty;
  assign evt_LocX    = w_head[c_LOCX_LSB +: c_FIELD_W];
  assign evt_LocY    = w_head[c_LOCY_LSB +: c_FIELD_W];
  assign evt_Sensors = w_head[c_SENS_LSB +: c_FIELD_W];
  assign evt_BotInfo = w_head[c_INFO_LSB +: c_FIELD_W];
  assign count       = w_count;
  assign overflow    = r_overflow;
  assign drop_cnt    = r_drop_cnt;
  assign irq_req     = r_irq_req;

endmodule
`default_nettype wire
